// File: rtl/digit_serial_subtractor.sv
// Digit-serial subtractor: Diff = X - Y - BorrowIn, one DIGIT-wide slice per clock, LSB first.
// Optional signed-overflow output is enabled by defining SUB_OVERFLOW_EN.
module digit_serial_subtractor #(
  parameter int WIDTH = 64,
  parameter int DIGIT = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic             borrow_in_i,
  output logic             ready_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             borrow_out_o,
  output logic             done_o
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             overflow_o
`endif
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   x_q, y_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               borrow_q;
  logic               borrow_out_q;
  logic [DIGIT:0]     slice_res;
  logic               accept;
  logic               running;
  logic               last_slice;

  assign accept     = (state_q == S_IDLE) && start_i;
  assign running    = (state_q == S_RUN);
  assign last_slice = (cnt_q == CNT_W'(N - 1));

  // The extra top bit of the (DIGIT+1)-bit difference is the borrow out of this slice.
  assign slice_res = {1'b0, x_q[DIGIT-1:0]} - {1'b0, y_q[DIGIT-1:0]}
                   - {{DIGIT{1'b0}}, borrow_q};

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (last_slice) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ready_o = (state_q == S_IDLE);
    busy_o  = (state_q == S_RUN);
    done_o  = (state_q == S_DONE);
  end

  // Operands shift right so the active slice always sits in the low DIGIT bits.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q          <= '0;
      y_q          <= '0;
      cnt_q        <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
    end else if (accept) begin
      x_q          <= x_i;
      y_q          <= y_i;
      cnt_q        <= '0;
      borrow_q     <= borrow_in_i;
      borrow_out_q <= 1'b0;
    end else if (running) begin
      x_q      <= x_q >> DIGIT;
      y_q      <= y_q >> DIGIT;
      cnt_q    <= cnt_q + 1'b1;
      borrow_q <= slice_res[DIGIT];
      if (last_slice) begin
        borrow_out_q <= slice_res[DIGIT];
      end
    end
  end

  assign borrow_out_o = borrow_out_q;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_slice
      logic [DIGIT-1:0] slice_q;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          slice_q <= '0;
        end else if (accept) begin
          slice_q <= '0;
        end else if (running && (cnt_q == CNT_W'(gi))) begin
          slice_q <= slice_res[DIGIT-1:0];
        end
      end

      assign diff_o[gi*DIGIT +: DIGIT] = slice_q;
    end
  endgenerate

`ifdef SUB_OVERFLOW_EN
  logic x_msb_q, y_msb_q, overflow_q;

  // The final slice's top bit is the result MSB, so overflow resolves with BorrowOut.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_msb_q    <= 1'b0;
      y_msb_q    <= 1'b0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      x_msb_q    <= x_i[WIDTH-1];
      y_msb_q    <= y_i[WIDTH-1];
      overflow_q <= 1'b0;
    end else if (running && last_slice) begin
      overflow_q <= (x_msb_q != y_msb_q) && (slice_res[DIGIT-1] != x_msb_q);
    end
  end

  assign overflow_o = overflow_q;
`endif

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Randomized + directed bench for digit_serial_subtractor against a cycle-level arithmetic model.
module tb_digit_serial_subtractor;
  localparam int WIDTH = 64;
  localparam int DIGIT = 8;
  localparam int N     = WIDTH / DIGIT;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, bi = 1'b0;
  logic [63:0] x = '0, y = '0;
  logic        ready, busy, done, bo;
  logic [63:0] diff;

  logic        start1 = 1'b0, bi1 = 1'b0;
  logic [63:0] x1 = '0, y1 = '0;
  logic        ready1, busy1, done1, bo1;
  logic [63:0] diff1;
`ifdef SUB_OVERFLOW_EN
  logic        ovf, ovf1;
`endif

  digit_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .x_i(x), .y_i(y), .borrow_in_i(bi),
    .ready_o(ready), .busy_o(busy), .diff_o(diff), .borrow_out_o(bo), .done_o(done)
`ifdef SUB_OVERFLOW_EN
    , .overflow_o(ovf)
`endif
  );

  digit_serial_subtractor #(.WIDTH(WIDTH), .DIGIT(64)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start1), .x_i(x1), .y_i(y1), .borrow_in_i(bi1),
    .ready_o(ready1), .busy_o(busy1), .diff_o(diff1), .borrow_out_o(bo1), .done_o(done1)
`ifdef SUB_OVERFLOW_EN
    , .overflow_o(ovf1)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  // Model: cycles remaining until idle, plus the arithmetic result of the last accepted op.
  int          m_rem  = 0;
  logic [63:0] m_diff = '0;
  logic        m_bo   = 1'b0;
`ifdef SUB_OVERFLOW_EN
  logic        m_ovf  = 1'b0;
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  = 0;
      m_diff = '0;
      m_bo   = 1'b0;
`ifdef SUB_OVERFLOW_EN
      m_ovf  = 1'b0;
`endif
    end else if (m_rem > 0) begin
      m_rem--;
    end else if (start) begin
      {m_bo, m_diff} = {1'b0, x} - {1'b0, y} - {64'd0, bi};
`ifdef SUB_OVERFLOW_EN
      m_ovf = (x[63] != y[63]) && (m_diff[63] != x[63]);
`endif
      m_rem = N + 1;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("ready", {63'd0, ready}, {63'd0, m_rem == 0});
      chk("busy",  {63'd0, busy},  {63'd0, m_rem >= 2});
      chk("done",  {63'd0, done},  {63'd0, m_rem == 1});
      if (m_rem <= 1) begin
        chk("diff", diff, m_diff);
        chk("borrow_out", {63'd0, bo}, {63'd0, m_bo});
`ifdef SUB_OVERFLOW_EN
        chk("overflow", {63'd0, ovf}, {63'd0, m_ovf});
`endif
      end
    end
  end

  task automatic wait_idle();
    int g = 0;
    @(negedge clk);
    while (m_rem != 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (m_rem != 0) chk("idle_timeout", 64'd1, 64'd0);
  endtask

  task automatic run_op(input logic [63:0] xa, input logic [63:0] ya, input logic bia,
                        output int lat, output logic [63:0] d, output logic b);
    wait_idle();
    x = xa; y = ya; bi = bia; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(posedge clk);
      #1 lat++;
      if (done) break;
    end
    d = diff;
    b = bo;
  endtask

  function automatic logic [63:0] rnd_operand();
    case ($urandom_range(0, 5))
      0:       return 64'd0;
      1:       return '1;
      2:       return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  int          lat;
  logic [63:0] d;
  logic        b;
  int          dcnt;

  initial begin
    #2;
    chk("rst_ready", {63'd0, ready}, 64'd1);
    chk("rst_busy",  {63'd0, busy},  64'd0);
    chk("rst_done",  {63'd0, done},  64'd0);
    chk("rst_diff",  diff, 64'd0);
    chk("rst_bo",    {63'd0, bo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, lat, d, b);
    chk("t1_latency", lat, 64'd8);
    chk("t1_diff", d, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("t1_bo", {63'd0, b}, 64'd1);

    run_op(64'd929, 64'd698, 1'b0, lat, d, b);
    chk("t2_diff", d, 64'd231);
    chk("t2_bo", {63'd0, b}, 64'd0);
    run_op(64'd1, 64'd1, 1'b0, lat, d, b);
    chk("t3_diff", d, 64'd0);
    chk("t3_bo", {63'd0, b}, 64'd0);

    run_op(64'd0, 64'd1, 1'b0, lat, d, b);
    chk("t4_diff", d, '1);
    chk("t4_bo", {63'd0, b}, 64'd1);
`ifdef SUB_OVERFLOW_EN
    chk("t4_ovf", {63'd0, ovf}, 64'd0);
`endif
    run_op(64'h8000_0000_0000_0000, 64'd1, 1'b0, lat, d, b);
    chk("t5_diff", d, 64'h7FFF_FFFF_FFFF_FFFF);
    chk("t5_bo", {63'd0, b}, 64'd0);
`ifdef SUB_OVERFLOW_EN
    chk("t5_ovf", {63'd0, ovf}, 64'd1);
`endif

    // Start held high with operands changing every cycle.
    wait_idle();
    dcnt = 0;
    for (int i = 0; i < 40; i++) begin
      start = 1'b1; x = {$urandom, $urandom}; y = {$urandom, $urandom}; bi = 1'($urandom);
      @(negedge clk);
      if (done) dcnt++;
    end
    start = 1'b0;
    chk("held_done_count", dcnt, 64'd4);

    // Reset while slice 4 is in progress.
    wait_idle();
    x = 64'd12345; y = 64'd54321; bi = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_ready", {63'd0, ready}, 64'd1);
    chk("mid_rst_busy",  {63'd0, busy},  64'd0);
    chk("mid_rst_done",  {63'd0, done},  64'd0);
    chk("mid_rst_diff",  diff, 64'd0);
    chk("mid_rst_bo",    {63'd0, bo}, 64'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    chk("mid_rst_no_done", dcnt, 64'd0);
    run_op(64'd1000, 64'd1, 1'b0, lat, d, b);
    chk("post_rst_diff", d, 64'd999);

    // Randomized traffic with random start activity.
    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 3) == 0);
      x = rnd_operand(); y = rnd_operand(); bi = 1'($urandom);
      @(negedge clk);
    end
    start = 1'b0;
    wait_idle();

    // Single-slice build.
    x1 = 64'd999999999; y1 = 64'd1; bi1 = 1'b0; start1 = 1'b1;
    @(posedge clk);
    #1 start1 = 1'b0;
    chk("d64_busy", {63'd0, busy1}, 64'd1);
    lat = 0;
    while (lat < 10) begin
      @(posedge clk);
      #1 lat++;
      if (done1) break;
    end
    chk("d64_latency", lat, 64'd1);
    chk("d64_diff", diff1, 64'd999999998);
    chk("d64_bo", {63'd0, bo1}, 64'd0);
    @(posedge clk);
    #1;
    chk("d64_ready", {63'd0, ready1}, 64'd1);
    chk("d64_hold", diff1, 64'd999999998);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
